// File: rtl/mem_ctrl.sv
// Dual APS6404 QPI PSRAM controller: powers both chips up into QPI mode, then serves
// single-byte accesses with the low nibble on U7 (SIO0-3) and the high nibble on U9 (SIO4-7).
package mem_ctrl_pkg;
    typedef enum logic [3:0] {
        stateInit_1, stateInit_2, stateEnableQPI, stateIdle, stateCmdAddr,
        stateWait, stateRdData, stateWrData, stateDeselect
    } state_t;
endpackage

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned initDelayInClkCyles = 7500,
    parameter logic [7:0]  enableQPIMode       = 8'h35,
    parameter logic [7:0]  CMD_WRITE           = 8'h38,
    parameter logic [7:0]  CMD_READ            = 8'hEB,
    parameter int unsigned READ_WAIT           = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CE,
    input  logic        write,
    input  logic [3:0]  bank,
    input  logic [15:0] addrBus,
    input  logic [7:0]  dataToWrite,
    output logic [7:0]  dataRead,
    output logic        busy,
    inout  wire         io_psram_data0,
    inout  wire         io_psram_data1,
    inout  wire         io_psram_data2,
    inout  wire         io_psram_data3,
    inout  wire         io_psram_data4,
    inout  wire         io_psram_data5,
    inout  wire         io_psram_data6,
    inout  wire         io_psram_data7,
    output logic        o_psram_cs,
    output logic        o_psram_sclk
);
    localparam int DLY_W = (initDelayInClkCyles < 2) ? 1 : $clog2(initDelayInClkCyles + 1);
    localparam logic [DLY_W-1:0] INIT_DLY = DLY_W'(initDelayInClkCyles);

    state_t            state_q, state_d, state;
    logic [DLY_W-1:0]  delay_q, delay_d, delayCounter;
    logic [31:0]       sr_q, sr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        data_read_q, data_read_d;
    logic              psram_cs_q, psram_cs_d, psram_cs;
    logic [7:0]        io_out, io_oe, io_in;

    assign state        = state_q;
    assign delayCounter = delay_q;
    assign psram_cs     = psram_cs_q;
    assign dataRead     = data_read_q;
    assign o_psram_cs   = psram_cs_q;
    assign o_psram_sclk = ~psram_cs_q & ~clk;

    assign io_in = {io_psram_data7, io_psram_data6, io_psram_data5, io_psram_data4,
                    io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};

    assign io_psram_data0 = io_oe[0] ? io_out[0] : 1'bz;
    assign io_psram_data1 = io_oe[1] ? io_out[1] : 1'bz;
    assign io_psram_data2 = io_oe[2] ? io_out[2] : 1'bz;
    assign io_psram_data3 = io_oe[3] ? io_out[3] : 1'bz;
    assign io_psram_data4 = io_oe[4] ? io_out[4] : 1'bz;
    assign io_psram_data5 = io_oe[5] ? io_out[5] : 1'bz;
    assign io_psram_data6 = io_oe[6] ? io_out[6] : 1'bz;
    assign io_psram_data7 = io_oe[7] ? io_out[7] : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= stateInit_1;
            delay_q     <= INIT_DLY;
            sr_q        <= '0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            data_read_q <= '0;
            psram_cs_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            data_read_q <= data_read_d;
            psram_cs_q  <= psram_cs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        data_read_d = data_read_q;
        busy        = 1'b1;
        case (state_q)
            stateInit_1: begin
                if (delay_q != '0) delay_d = delay_q - 1'b1;
                if (delay_q <= DLY_W'(1)) state_d = stateInit_2;
            end
            stateInit_2: begin
                sr_d    = {enableQPIMode, 24'h0};
                cnt_d   = 4'd7;
                state_d = stateEnableQPI;
            end
            stateEnableQPI: begin
                sr_d  = sr_q << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = stateIdle;
            end
            stateIdle: begin
                busy = 1'b0;
                if (CE) begin
                    wr_d    = write;
                    wdata_d = dataToWrite;
                    sr_d    = {(write ? CMD_WRITE : CMD_READ), 4'h0, bank, addrBus};
                    cnt_d   = 4'd7;
                    state_d = stateCmdAddr;
                end
            end
            stateCmdAddr: begin
                sr_d  = sr_q << 4;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    if (wr_q) begin
                        state_d = stateWrData;
                    end else begin
                        cnt_d   = 4'(READ_WAIT - 1);
                        state_d = stateWait;
                    end
                end
            end
            stateWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = stateRdData;
            end
            stateRdData: begin
                data_read_d = io_in;
                state_d     = stateDeselect;
            end
            stateWrData:   state_d = stateDeselect;
            stateDeselect: state_d = stateIdle;
            default:       state_d = stateInit_1;
        endcase
        // CS is registered from the next state so the chip select never glitches
        psram_cs_d = !(state_d inside {stateEnableQPI, stateCmdAddr, stateWait,
                                       stateRdData, stateWrData});
    end

    always_comb begin
        io_out = '0;
        io_oe  = '0;
        case (state_q)
            stateEnableQPI: begin
                // SPI mode: SI carries the command, WP#/HOLD# held inactive, SO left floating
                io_oe  = 8'b1101_1101;
                io_out = {1'b1, 1'b1, 1'b0, sr_q[31], 1'b1, 1'b1, 1'b0, sr_q[31]};
            end
            stateCmdAddr: begin
                io_oe  = 8'hFF;
                io_out = {sr_q[31:28], sr_q[31:28]};
            end
            stateWrData: begin
                io_oe  = 8'hFF;
                io_out = wdata_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural dual-PSRAM model on the bus, byte-level reference memory,
// directed init/write/read/reset steps followed by random byte traffic.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int INIT_DLY  = 7500;
    localparam int READ_WAIT = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        CE = 1'b0, write = 1'b0;
    logic [3:0]  bank = '0;
    logic [15:0] addrBus = '0;
    logic [7:0]  dataToWrite = '0;
    logic [7:0]  dataRead;
    logic        busy, o_psram_cs, o_psram_sclk;
    wire         io0, io1, io2, io3, io4, io5, io6, io7;

    int total = 0;
    int bad = 0;

    mem_ctrl dut (
        .clk(clk), .reset(reset), .CE(CE), .write(write), .bank(bank), .addrBus(addrBus),
        .dataToWrite(dataToWrite), .dataRead(dataRead), .busy(busy),
        .io_psram_data0(io0), .io_psram_data1(io1), .io_psram_data2(io2), .io_psram_data3(io3),
        .io_psram_data4(io4), .io_psram_data5(io5), .io_psram_data6(io6), .io_psram_data7(io7),
        .o_psram_cs(o_psram_cs), .o_psram_sclk(o_psram_sclk)
    );

    always #5 clk = ~clk;

    // ---------------- PSRAM pair model ----------------
    logic        qpi = 1'b0;
    logic [7:0]  spi_sr = '0;
    int          spi_bits = 0;
    int          nib_cnt = 0;
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;
    logic [3:0]  mem_lo [logic [23:0]];
    logic [3:0]  mem_hi [logic [23:0]];
    logic [3:0]  nib_log [$];
    int          group_diff = 0;
    int          sessions = 0;
    int          cs_low_clks = 0;
    logic        drv_en = 1'b0;
    logic [7:0]  drv_val = '0;

    assign io0 = drv_en ? drv_val[0] : 1'bz;
    assign io1 = drv_en ? drv_val[1] : 1'bz;
    assign io2 = drv_en ? drv_val[2] : 1'bz;
    assign io3 = drv_en ? drv_val[3] : 1'bz;
    assign io4 = drv_en ? drv_val[4] : 1'bz;
    assign io5 = drv_en ? drv_val[5] : 1'bz;
    assign io6 = drv_en ? drv_val[6] : 1'bz;
    assign io7 = drv_en ? drv_val[7] : 1'bz;

    always @(negedge o_psram_cs) begin
        sessions++;
        spi_bits = 0;
        nib_cnt  = 0;
        m_cmd    = '0;
        m_addr   = '0;
    end

    always @(posedge o_psram_cs) begin
        drv_en = 1'b0;
        if (!qpi && spi_bits == 8 && spi_sr == 8'h35) qpi = 1'b1;
    end

    always @(posedge o_psram_sclk) begin
        logic [3:0] lo, hi;
        lo = {io3, io2, io1, io0};
        hi = {io7, io6, io5, io4};
        if (!qpi) begin
            spi_sr = {spi_sr[6:0], io0};
            spi_bits++;
        end else begin
            if (nib_cnt < 8) begin
                nib_log.push_back(lo);
                if (lo != hi) group_diff++;
                if (nib_cnt < 2) m_cmd = {m_cmd[3:0], lo};
                else             m_addr = {m_addr[19:0], lo};
            end else if (nib_cnt == 8 && m_cmd == 8'h38) begin
                mem_lo[m_addr] = lo;
                mem_hi[m_addr] = hi;
            end
            nib_cnt++;
        end
    end

    // read data leaves the chips on the SCLK falling edge after the wait cycles
    always @(negedge o_psram_sclk) begin
        if (qpi && m_cmd == 8'hEB && nib_cnt == 8 + READ_WAIT) begin
            drv_val = {mem_hi.exists(m_addr) ? mem_hi[m_addr] : 4'h0,
                       mem_lo.exists(m_addr) ? mem_lo[m_addr] : 4'h0};
            drv_en  = 1'b1;
        end
    end

    always @(negedge clk) if (o_psram_cs === 1'b0) cs_low_clks++;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic wr, input logic [23:0] a, input logic [7:0] d);
        int n, sess0;
        sess0 = sessions;
        cs_low_clks = 0;
        CE = 1'b1; write = wr; bank = a[19:16]; addrBus = a[15:0]; dataToWrite = d;
        tick();
        CE = 1'b0;
        n = 1;
        while (busy && n < 60) begin
            if (n == 3) begin CE = 1'b1; write = ~wr; addrBus = ~a[15:0]; end
            if (n == 5) CE = 1'b0;
            tick();
            n++;
        end
        if (wr) begin
            chk("wr_busy_cycles", n - 1, 2 + 6 + 1 + 1);
            chk("wr_cs_low_clks", cs_low_clks, 2 + 6 + 1);
        end else begin
            chk("rd_busy_cycles", n - 1, 2 + 6 + READ_WAIT + 1 + 1);
            chk("rd_cs_low_clks", cs_low_clks, 2 + 6 + READ_WAIT + 1);
        end
        chk("cs_sessions_per_op", sessions - sess0, 1);
        chk("cs_high_after_op", o_psram_cs, 1);
    endtask

    // ---------------- reference + stimulus ----------------
    logic [7:0]  ref_mem [logic [23:0]];
    logic [23:0] waddrs [$];
    logic [7:0]  qcmd;
    logic [3:0]  exp_nib [8];
    logic [23:0] ra;
    logic [7:0]  rd;

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_delayCounter", 32'(dut.delayCounter), INIT_DLY);
        chk("rst_state", 32'(dut.state), 32'(stateInit_1));
        chk("rst_cs", o_psram_cs, 1);
        chk("rst_busy", busy, 1);
        chk("rst_dataRead", dataRead, 0);
        chk("rst_io_oe", 32'(dut.io_oe), 0);
        chk("rst_sclk", o_psram_sclk, 0);

        // power-up delay
        reset = 1'b1;
        repeat (INIT_DLY - 1) tick();
        chk("init1_last_cycle", 32'(dut.state), 32'(stateInit_1));
        tick();
        chk("init2_state", 32'(dut.state), 32'(stateInit_2));
        chk("init2_cs", dut.psram_cs, 1);
        tick();
        chk("qpi_state", 32'(dut.state), 32'(stateEnableQPI));
        chk("qpi_cs", dut.psram_cs, 0);

        // SPI enable-QPI command
        qcmd = 8'h35;
        for (int i = 0; i < 8; i++) begin
            chk("qpi_si0", io0, qcmd[7 - i]);
            chk("qpi_si4", io4, qcmd[7 - i]);
            chk("qpi_so1_z", dut.io_oe[1], 0);
            chk("qpi_so5_z", dut.io_oe[5], 0);
            chk("qpi_wp_hold", {io7, io6, io3, io2}, 4'hF);
            tick();
        end
        chk("idle_state", 32'(dut.state), 32'(stateIdle));
        chk("idle_busy", busy, 0);
        chk("idle_cs", o_psram_cs, 1);
        chk("model_in_qpi", qpi, 1);
        chk("model_spi_byte", spi_sr, 8'h35);
        repeat (5) tick();
        chk("idle_hold", 32'(dut.state), 32'(stateIdle));
        chk("idle_io_z", 32'(dut.io_oe), 0);

        // directed write
        exp_nib = '{4'h3, 4'h8, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        nib_log.delete();
        run_op(1'b1, 24'h012345, 8'hA5);
        ref_mem[24'h012345] = 8'hA5;
        waddrs.push_back(24'h012345);
        for (int i = 0; i < 8; i++)
            chk("wr_cmd_addr_nibble", (i < nib_log.size()) ? 32'(nib_log[i]) : 32'hDEAD,
                32'(exp_nib[i]));
        chk("wr_u7_nibble", mem_lo.exists(24'h012345) ? 32'(mem_lo[24'h012345]) : 32'hDEAD, 4'h5);
        chk("wr_u9_nibble", mem_hi.exists(24'h012345) ? 32'(mem_hi[24'h012345]) : 32'hDEAD, 4'hA);
        chk("wr_busy_low", busy, 0);

        // directed read
        run_op(1'b0, 24'h012345, 8'h00);
        chk("rd_dataRead", dataRead, 8'hA5);

        // random traffic
        for (int k = 0; k < 30; k++) begin
            if (waddrs.size() < 3 || $urandom_range(0, 1) == 1) begin
                ra = {4'h0, 4'($urandom_range(0, 15)), 16'($urandom)};
                rd = 8'($urandom);
                run_op(1'b1, ra, rd);
                ref_mem[ra] = rd;
                waddrs.push_back(ra);
                chk("rnd_wr_stored", {mem_hi.exists(ra) ? mem_hi[ra] : 4'h0,
                                      mem_lo.exists(ra) ? mem_lo[ra] : 4'h0}, rd);
            end else begin
                ra = waddrs[$urandom_range(0, waddrs.size() - 1)];
                run_op(1'b0, ra, 8'($urandom));
                chk("rnd_rd_data", dataRead, ref_mem[ra]);
            end
        end
        chk("group_diff_count", group_diff, 0);

        // reset in the middle of a read
        CE = 1'b1; write = 1'b0; bank = 4'h1; addrBus = 16'h2345;
        tick();
        CE = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        chk("abort_cs", o_psram_cs, 1);
        chk("abort_io_z", 32'(dut.io_oe), 0);
        chk("abort_state", 32'(dut.state), 32'(stateInit_1));
        chk("abort_delayCounter", 32'(dut.delayCounter), INIT_DLY);
        chk("abort_busy", busy, 1);
        chk("abort_sclk", o_psram_sclk, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
